// File: rtl/wb_gpio_in_if.sv
// Wishbone pipelined bus bundle shared by the GPIO input slave and its bus master.
interface wb_if (
    input logic clk,
    input logic rst
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_m;
    logic        ack;
    logic        stall;
    logic        err;
    logic [31:0] dat_s;

    modport slave (
        input  clk, rst, cyc, stb, we, adr, sel, dat_m,
        output ack, stall, err, dat_s
    );

    modport master (
        input  clk, rst, ack, stall, err, dat_s,
        output cyc, stb, we, adr, sel, dat_m
    );
endinterface

// File: rtl/wb_gpio_in.sv
// Wishbone slave for board inputs: per-pin sync + debounce, sticky edge capture, register readout.
// Optional irq output and IRQ_MASK register are enabled with WB_GPIO_IN_IRQ_EN.
module wb_gpio_in_lane #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic raw,
    output logic data,
    output logic rise_ev,
    output logic fall_ev
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic [CW-1:0] cnt;
    logic          flip;

    assign flip    = (raw != data) && (cnt == CNT_LAST);
    assign rise_ev = flip & raw;
    assign fall_ev = flip & ~raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            raw  <= 1'b0;
            data <= 1'b0;
            cnt  <= '0;
        end else begin
            s1  <= pin;
            raw <= s1;
            if (raw == data) begin
                cnt <= '0;
            end else if (flip) begin
                data <= raw;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module wb_gpio_in #(
    parameter int N               = 1,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    wb_if.slave         wb,
    input  logic [N-1:0] gpio_in
`ifdef WB_GPIO_IN_IRQ_EN
    ,
    output logic         irq
`endif
);
    logic [N-1:0] raw, data, rise_ev, fall_ev;
    logic [N-1:0] rise, fall;
    logic [31:0]  rdata;
    logic [31:0]  be;
    logic [31:0]  wmask;
    logic [2:0]   widx;
    logic         req;
    logic         wr;
    logic [N-1:0] clr_r, clr_f;
    logic         unused_bits;

    for (genvar i = 0; i < N; i++) begin : g_lane
        wb_gpio_in_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
            .clk     (wb.clk),
            .rst     (wb.rst),
            .pin     (gpio_in[i]),
            .raw     (raw[i]),
            .data    (data[i]),
            .rise_ev (rise_ev[i]),
            .fall_ev (fall_ev[i])
        );
    end

    assign req   = wb.cyc & wb.stb;
    assign wr    = req & wb.we;
    assign widx  = wb.adr[4:2];
    assign be    = {{8{wb.sel[3]}}, {8{wb.sel[2]}}, {8{wb.sel[1]}}, {8{wb.sel[0]}}};
    assign wmask = wb.dat_m & be;
    assign clr_r = (wr && widx == 3'd1) ? wmask[N-1:0] : '0;
    assign clr_f = (wr && widx == 3'd2) ? wmask[N-1:0] : '0;

    assign wb.stall = 1'b0;
    assign wb.err   = 1'b0;

    assign unused_bits = ^{wb.adr[31:5], wb.adr[1:0], wmask};

`ifdef WB_GPIO_IN_IRQ_EN
    logic [N-1:0] mask_r, mask_f;
`endif

    always_comb begin
        rdata = '0;
        case (widx)
            3'd0: rdata = 32'(data);
            3'd1: rdata = 32'(rise);
            3'd2: rdata = 32'(fall);
            3'd3: rdata = 32'(raw);
`ifdef WB_GPIO_IN_IRQ_EN
            3'd4: rdata = {16'(mask_f), 16'(mask_r)};
`endif
            default: rdata = '0;
        endcase
    end

    // A new edge event overrides a same-cycle W1C clear of that bit.
    always_ff @(posedge wb.clk) begin
        if (wb.rst) begin
            wb.ack   <= 1'b0;
            wb.dat_s <= '0;
            rise     <= '0;
            fall     <= '0;
        end else begin
            wb.ack   <= req;
            wb.dat_s <= req ? rdata : '0;
            rise     <= (rise & ~clr_r) | rise_ev;
            fall     <= (fall & ~clr_f) | fall_ev;
        end
    end

`ifdef WB_GPIO_IN_IRQ_EN
    always_ff @(posedge wb.clk) begin
        if (wb.rst) begin
            mask_r <= '0;
            mask_f <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr && widx == 3'd4) begin
                mask_r <= (mask_r & ~be[N-1:0])      | (wb.dat_m[N-1:0]      & be[N-1:0]);
                mask_f <= (mask_f & ~be[16 +: N])    | (wb.dat_m[16 +: N]    & be[16 +: N]);
            end
            irq <= (|(rise & mask_r)) | (|(fall & mask_f));
        end
    end
`endif
endmodule

// File: tb/tb_wb_gpio_in.sv
// Directed bench for wb_gpio_in (N=4, DEBOUNCE_CYCLES=4); read data checked through an expected-value queue.
module tb_wb_gpio_in;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] gpio_in = 4'h0;
`ifdef WB_GPIO_IN_IRQ_EN
    logic       irq;
`endif

    always #5 clk = ~clk;

    wb_if wb (.clk(clk), .rst(rst));

    wb_gpio_in #(.N(4), .DEBOUNCE_CYCLES(4)) dut (
        .wb      (wb),
        .gpio_in (gpio_in)
`ifdef WB_GPIO_IN_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    int          nassert = 0;
    int          nfail   = 0;
    logic [31:0] sbq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        wb.cyc   = 1'b0;
        wb.stb   = 1'b0;
        wb.we    = 1'b0;
        wb.adr   = '0;
        wb.sel   = '0;
        wb.dat_m = '0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        sbq.push_back(exp);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = a; wb.sel = 4'hF; wb.dat_m = '0;
        tick();
        drop();
        chk({tag, ".ack"}, 32'(wb.ack), 32'd1);
        e = sbq.pop_front();
        if (wb.ack === 1'b1) chk(tag, wb.dat_s, e);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input string tag);
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b1; wb.adr = a; wb.sel = s; wb.dat_m = d;
        tick();
        drop();
        chk({tag, ".ack"}, 32'(wb.ack), 32'd1);
    endtask

    task automatic idle_chk(input string tag);
        tick();
        chk({tag, ".ack_once"}, 32'(wb.ack), 32'd0);
        chk({tag, ".dat_idle"}, wb.dat_s, 32'd0);
    endtask

    initial begin
        drop();
        repeat (3) tick();
        chk("rst.ack",   32'(wb.ack),   32'd0);
        chk("rst.err",   32'(wb.err),   32'd0);
        chk("rst.stall", 32'(wb.stall), 32'd0);
        chk("rst.dat_s", wb.dat_s,      32'd0);
`ifdef WB_GPIO_IN_IRQ_EN
        chk("rst.irq",   32'(irq),      32'd0);
`endif
        rst = 1'b0;
        tick();

        // Registers after reset, each single-cycle ack
        rd(32'h00, 32'h0, "t1.data"); idle_chk("t1.data");
        rd(32'h04, 32'h0, "t1.rise"); idle_chk("t1.rise");
        rd(32'h08, 32'h0, "t1.fall"); idle_chk("t1.fall");
        rd(32'h0C, 32'h0, "t1.raw");  idle_chk("t1.raw");
        rd(32'h10, 32'h0, "t1.x10");

        // Clean edge: RAW two edges later, DATA/RISE six edges later
        gpio_in = 4'h5;
        tick();
        rd(32'h0C, 32'h0, "t2.raw_e2");
        rd(32'h0C, 32'h5, "t2.raw_e3");
        rd(32'h00, 32'h0, "t2.data_e4");
        rd(32'h00, 32'h0, "t2.data_e5");
        rd(32'h00, 32'h0, "t2.data_e6");
        rd(32'h00, 32'h5, "t2.data_e7");
        rd(32'h04, 32'h5, "t2.rise");
        rd(32'h08, 32'h0, "t2.fall");
        chk("t2.err", 32'(wb.err), 32'd0);

        // Three-cycle glitch on bit 1 is visible on RAW only
        gpio_in = 4'h7;
        rd(32'h0C, 32'h5, "t3.raw_e1");
        rd(32'h0C, 32'h5, "t3.raw_e2");
        rd(32'h0C, 32'h7, "t3.raw_e3");
        gpio_in = 4'h5;
        rd(32'h0C, 32'h7, "t3.raw_e4");
        rd(32'h0C, 32'h7, "t3.raw_e5");
        rd(32'h0C, 32'h5, "t3.raw_e6");
        repeat (8) tick();
        rd(32'h00, 32'h5, "t3.data");
        rd(32'h04, 32'h5, "t3.rise");
        rd(32'h08, 32'h0, "t3.fall");

        // W1C with byte-lane enables, RO and unmapped writes
        wr(32'h04, 32'h1, 4'h1, "t4.w1c");
        rd(32'h04, 32'h4, "t4.rise_a");
        wr(32'h04, 32'h4, 4'h0, "t4.w1c_nosel");
        rd(32'h04, 32'h4, "t4.rise_b");
        wr(32'h00, 32'hF, 4'hF, "t4.wr_ro");
        rd(32'h00, 32'h5, "t4.data_ro");
        wr(32'h14, 32'hFFFF_FFFF, 4'hF, "t4.wr_x14");
        rd(32'h14, 32'h0, "t4.x14");
        rd(32'h1C, 32'h0, "t4.x1c");
`ifdef WB_GPIO_IN_IRQ_EN
        wr(32'h10, 32'h0001_0000, 4'hF, "t6.mask");
        rd(32'h10, 32'h0001_0000, "t6.mask_rd");
        chk("t6.irq_idle", 32'(irq), 32'd0);
`else
        wr(32'h10, 32'h0001_0000, 4'hF, "t4.wr_x10");
        rd(32'h10, 32'h0, "t4.x10");
`endif

        // Falling edge on bit 0; with IRQ enabled, irq follows FALL by one cycle
        gpio_in = 4'h4;
        repeat (6) tick();
`ifdef WB_GPIO_IN_IRQ_EN
        chk("t6.irq_pre", 32'(irq), 32'd0);
`endif
        tick();
`ifdef WB_GPIO_IN_IRQ_EN
        chk("t6.irq_set", 32'(irq), 32'd1);
`endif
        rd(32'h08, 32'h1, "t6.fall");
        rd(32'h00, 32'h4, "t6.data");
        wr(32'h08, 32'h1, 4'hF, "t6.w1c");
`ifdef WB_GPIO_IN_IRQ_EN
        chk("t6.irq_hold", 32'(irq), 32'd1);
`endif
        tick();
`ifdef WB_GPIO_IN_IRQ_EN
        chk("t6.irq_clr", 32'(irq), 32'd0);
`endif
        rd(32'h08, 32'h0, "t6.fall_clr");

        // W1C on the same edge a new rise sets bit 0: the set wins
        gpio_in = 4'h5;
        repeat (5) tick();
        wr(32'h04, 32'h1, 4'h1, "t5.w1c_race");
        rd(32'h04, 32'h5, "t5.rise_race");
        wr(32'h04, 32'h1, 4'h1, "t5.w1c_plain");
        rd(32'h04, 32'h4, "t5.rise_plain");

        // Reset on a request edge drops the response and clears state
        wb.cyc = 1'b1; wb.stb = 1'b1; wb.we = 1'b0; wb.adr = 32'h00; wb.sel = 4'hF;
        rst = 1'b1;
        tick();
        drop();
        chk("rst2.ack",   32'(wb.ack), 32'd0);
        chk("rst2.dat_s", wb.dat_s,    32'd0);
        rst = 1'b0;
        rd(32'h00, 32'h0, "rst2.data");
        rd(32'h04, 32'h0, "rst2.rise");
        repeat (6) tick();
        rd(32'h04, 32'h5, "rst2.rise_held");

        // cyc=0 with stb=1 is not a request
        wb.stb = 1'b1; wb.adr = 32'h00;
        tick();
        drop();
        chk("nocyc.ack", 32'(wb.ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end
endmodule
